// File: rtl/eth_tx_arbiter_if.sv
// Shared GMII transmit bus: ARP/UDP source handshakes plus the PHY byte stream.
// The sources drive the master side and the arbiter drives the slave side.
interface eth_tx_arbiter_if;
  logic       i_arp_req;
  logic       o_arp_gnt;
  logic [7:0] i_arp_data;
  logic       i_arp_en;
  logic       i_udp_req;
  logic       o_udp_gnt;
  logic [7:0] i_udp_data;
  logic       i_udp_en;
  logic [7:0] eth_tx_data;
  logic       eth_tx_data_en;

  modport master (
    output i_arp_req, i_arp_data, i_arp_en,
    output i_udp_req, i_udp_data, i_udp_en,
    input  o_arp_gnt, o_udp_gnt, eth_tx_data, eth_tx_data_en
  );

  modport slave (
    input  i_arp_req, i_arp_data, i_arp_en,
    input  i_udp_req, i_udp_data, i_udp_en,
    output o_arp_gnt, o_udp_gnt, eth_tx_data, eth_tx_data_en
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Arbitrates the GMII transmit path between the ARP sender and the UDP generator.
// ARP has priority with bounded UDP anti-starvation; it also enforces IFG, start timeout and frame-length truncation.
module eth_tx_arbiter #(
  parameter int unsigned IFG_CYCLES    = 12,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned MAX_FRAME_LEN = 1530,
  parameter int unsigned ARP_BURST_MAX = 4
) (
  input  logic                   eth_tx_clk,
  input  logic                   rst_n,
  eth_tx_arbiter_if.slave        bus,
  output logic                   o_busy,
  output logic [15:0]            o_arp_frames,
  output logic [15:0]            o_udp_frames,
  output logic [7:0]             o_err_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_XMIT  = 3'd2;
  localparam logic [2:0] S_TRUNC = 3'd3;
  localparam logic [2:0] S_IFG   = 3'd4;

  localparam logic [6:0]  TMO_LAST  = 7'(START_TIMEOUT - 1);
  localparam logic [10:0] LEN_MAX   = 11'(MAX_FRAME_LEN);
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_CYCLES - 1);
  localparam logic [3:0]  BURST_MAX = 4'(ARP_BURST_MAX);

  logic [2:0]  state_q,   state_d;
  logic        owner_q,   owner_d;
  logic        arp_req_q, udp_req_q;
  logic [3:0]  burst_q,   burst_d;
  logic [6:0]  tmo_q,     tmo_d;
  logic [10:0] byte_q,    byte_d;
  logic [7:0]  ifg_q,     ifg_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q,   tx_en_d;
  logic [15:0] arp_frm_q, arp_frm_d;
  logic [15:0] udp_frm_q, udp_frm_d;
  logic [7:0]  err_q,     err_d;

  logic        own_req, own_en;
  logic [7:0]  own_data;
  logic        err_evt, frame_done, owned;

  // owner_q: 0 = ARP, 1 = UDP; the other source is never looked at
  assign own_req  = owner_q ? bus.i_udp_req  : bus.i_arp_req;
  assign own_en   = owner_q ? bus.i_udp_en   : bus.i_arp_en;
  assign own_data = owner_q ? bus.i_udp_data : bus.i_arp_data;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    tmo_d      = tmo_q;
    byte_d     = byte_q;
    ifg_d      = ifg_q;
    tx_data_d  = '0;
    tx_en_d    = 1'b0;
    err_evt    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arp_req_q && !(burst_q == BURST_MAX && udp_req_q)) begin
          owner_d = 1'b0;
          state_d = S_GRANT;
          tmo_d   = '0;
          if (udp_req_q) burst_d = burst_q + 4'd1;
        end else if (udp_req_q) begin
          owner_d = 1'b1;
          state_d = S_GRANT;
          tmo_d   = '0;
          burst_d = '0;
        end
      end
      S_GRANT: begin
        if (own_en) begin
          state_d   = S_XMIT;
          tx_data_d = own_data;
          tx_en_d   = 1'b1;
          byte_d    = 11'd1;
        end else if (!own_req) begin
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IFG;
          ifg_d   = '0;
          err_evt = 1'b1;
        end else begin
          tmo_d = tmo_q + 7'd1;
        end
      end
      S_XMIT: begin
        if (!own_en) begin
          state_d    = S_IFG;
          ifg_d      = '0;
          frame_done = 1'b1;
        end else if (byte_q == LEN_MAX) begin
          state_d = S_TRUNC;
          err_evt = 1'b1;
        end else begin
          tx_data_d = own_data;
          tx_en_d   = 1'b1;
          byte_d    = byte_q + 11'd1;
        end
      end
      S_TRUNC: begin
        if (!own_en) begin
          state_d = S_IFG;
          ifg_d   = '0;
        end
      end
      S_IFG: begin
        if (ifg_q == IFG_LAST) state_d = S_IDLE;
        else                   ifg_d   = ifg_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arp_frm_d = arp_frm_q;
    udp_frm_d = udp_frm_q;
    err_d     = err_q;
    if (frame_done && !owner_q) arp_frm_d = arp_frm_q + 16'd1;
    if (frame_done &&  owner_q) udp_frm_d = udp_frm_q + 16'd1;
    if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      arp_req_q <= 1'b0;
      udp_req_q <= 1'b0;
      burst_q   <= '0;
      tmo_q     <= '0;
      byte_q    <= '0;
      ifg_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      arp_frm_q <= '0;
      udp_frm_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arp_req_q <= bus.i_arp_req;
      udp_req_q <= bus.i_udp_req;
      burst_q   <= burst_d;
      tmo_q     <= tmo_d;
      byte_q    <= byte_d;
      ifg_q     <= ifg_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      arp_frm_q <= arp_frm_d;
      udp_frm_q <= udp_frm_d;
      err_q     <= err_d;
    end
  end

  assign owned              = (state_q == S_GRANT) || (state_q == S_XMIT) || (state_q == S_TRUNC);
  assign bus.o_arp_gnt      = owned && !owner_q;
  assign bus.o_udp_gnt      = owned &&  owner_q;
  assign bus.eth_tx_data    = tx_data_q;
  assign bus.eth_tx_data_en = tx_en_q;
  assign o_busy             = (state_q != S_IDLE);
  assign o_arp_frames       = arp_frm_q;
  assign o_udp_frames       = udp_frm_q;
  assign o_err_cnt          = err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: a byte scoreboard fed by the stimulus
// is drained by a bus monitor, and each scenario task checks grants, counters and timing.
module tb_eth_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #4 clk = ~clk;

  eth_tx_arbiter_if bus();
  logic        o_busy;
  logic [15:0] o_arp_frames, o_udp_frames;
  logic [7:0]  o_err_cnt;

  eth_tx_arbiter #(
    .IFG_CYCLES(12), .START_TIMEOUT(64), .MAX_FRAME_LEN(1530), .ARP_BURST_MAX(4)
  ) dut (
    .eth_tx_clk  (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_arp_frames(o_arp_frames),
    .o_udp_frames(o_udp_frames),
    .o_err_cnt   (o_err_cnt)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         bytes_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (bus.eth_tx_data_en === 1'b1) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          $display("FAIL bus_byte: got unexpected byte %02h, expected no byte", bus.eth_tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.eth_tx_data !== mon_exp)
            $display("FAIL bus_byte: got %02h expected %02h", bus.eth_tx_data, mon_exp);
          else n_pass++;
        end
      end else if (bus.eth_tx_data !== 8'h00) begin
        $display("FAIL idle_data: got %02h expected 00", bus.eth_tx_data);
      end else n_pass++;
      n_checks++;
      if ((bus.o_arp_gnt & bus.o_udp_gnt) !== 1'b0)
        $display("FAIL gnt_onehot: got arp=%b udp=%b expected at most one", bus.o_arp_gnt, bus.o_udp_gnt);
      else n_pass++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_arp_req = 1'b0; bus.i_arp_en = 1'b0; bus.i_arp_data = '0;
    bus.i_udp_req = 1'b0; bus.i_udp_en = 1'b0; bus.i_udp_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(output bit ok, output bit who, output int waited);
    ok = 1'b0; who = 1'b0; waited = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      waited++;
      if (bus.o_arp_gnt === 1'b1 || bus.o_udp_gnt === 1'b1) begin
        ok  = 1'b1;
        who = bus.o_udp_gnt;
      end
    end
  endtask

  // Drives n contiguous bytes from src (0=ARP, 1=UDP); only the first 'limit' are expected on the bus.
  task automatic run_frame(input bit src, input int n, input int limit, input bit drop_req,
                           output bit gnt_held, output bit lag_ok);
    logic [7:0] d;
    gnt_held = 1'b1;
    lag_ok   = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom_range(0, 255));
      if (src) begin bus.i_udp_en = 1'b1; bus.i_udp_data = d; end
      else     begin bus.i_arp_en = 1'b1; bus.i_arp_data = d; end
      if (i < limit) exp_q.push_back(d);
      tick();
      if (i == 0) lag_ok = (bus.eth_tx_data_en === 1'b1) && (bus.eth_tx_data === d);
      if ((src ? bus.o_udp_gnt : bus.o_arp_gnt) !== 1'b1) gnt_held = 1'b0;
    end
    bus.i_arp_en = 1'b0; bus.i_arp_data = '0;
    bus.i_udp_en = 1'b0; bus.i_udp_data = '0;
    if (drop_req) begin
      if (src) bus.i_udp_req = 1'b0;
      else     bus.i_arp_req = 1'b0;
    end
    tick();
  endtask

  task automatic measure_ifg(output int cycles, output bit clean);
    cycles = 0;
    clean  = 1'b1;
    while (o_busy === 1'b1 && cycles < 100) begin
      if (bus.eth_tx_data_en !== 1'b0 || bus.o_arp_gnt !== 1'b0 || bus.o_udp_gnt !== 1'b0) clean = 1'b0;
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.o_arp_gnt, bus.o_udp_gnt, bus.eth_tx_data_en, o_busy} !== 4'b0 ||
        o_arp_frames !== 16'd0 || o_udp_frames !== 16'd0 || o_err_cnt !== 8'd0)
      $display("FAIL reset_state: got gnt=%b%b en=%b busy=%b arp=%0d udp=%0d err=%0d expected all 0",
               bus.o_arp_gnt, bus.o_udp_gnt, bus.eth_tx_data_en, o_busy, o_arp_frames, o_udp_frames, o_err_cnt);
    else n_pass++;
  endtask

  task automatic test_arp_frame();
    bit ok, who, held, lag, clean;
    int w, ifg;
    do_reset();
    bus.i_arp_req = 1'b1;
    wait_gnt(ok, who, w);
    n_checks++;
    if (!ok || who !== 1'b0 || w != 2) $display("FAIL arp_grant: got ok=%b udp=%b after %0d cycles expected arp after 2", ok, who, w);
    else n_pass++;
    bytes_seen = 0;
    run_frame(1'b0, 42, 42, 1'b1, held, lag);
    n_checks++;
    if (!lag) $display("FAIL arp_lag: got first byte not on bus next cycle expected 1-cycle latency");
    else n_pass++;
    n_checks++;
    if (bytes_seen != 42 || exp_q.size() != 0) $display("FAIL arp_len: got %0d bytes expected 42", bytes_seen);
    else n_pass++;
    n_checks++;
    if (o_arp_frames !== 16'd1 || o_udp_frames !== 16'd0) $display("FAIL arp_frames: got arp=%0d udp=%0d expected 1/0", o_arp_frames, o_udp_frames);
    else n_pass++;
    measure_ifg(ifg, clean);
    n_checks++;
    if (ifg != 12 || !clean) $display("FAIL arp_ifg: got %0d cycles clean=%b expected 12 clean", ifg, clean);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit ok, who, held, lag, clean;
    int w, ifg;
    do_reset();
    bus.i_arp_req = 1'b1;
    bus.i_udp_req = 1'b1;
    wait_gnt(ok, who, w);
    n_checks++;
    if (!ok || who !== 1'b0) $display("FAIL simul_first: got ok=%b udp=%b expected arp", ok, who);
    else n_pass++;
    run_frame(1'b0, 20, 20, 1'b1, held, lag);
    measure_ifg(ifg, clean);
    wait_gnt(ok, who, w);
    n_checks++;
    if (ifg != 12 || !clean || !ok || who !== 1'b1 || w != 1)
      $display("FAIL simul_second: got ifg=%0d ok=%b udp=%b wait=%0d expected ifg=12 udp wait=1", ifg, ok, who, w);
    else n_pass++;
    run_frame(1'b1, 30, 30, 1'b1, held, lag);
    measure_ifg(ifg, clean);
    n_checks++;
    if (o_arp_frames !== 16'd1 || o_udp_frames !== 16'd1 || exp_q.size() != 0)
      $display("FAIL simul_frames: got arp=%0d udp=%0d expected 1/1", o_arp_frames, o_udp_frames);
    else n_pass++;
  endtask

  task automatic test_starvation();
    bit ok, who, held, lag, clean;
    int w, ifg;
    bit exp_order[$];
    bit e;
    do_reset();
    for (int k = 0; k < 10; k++) exp_order.push_back((k % 5) == 4);
    bus.i_arp_req = 1'b1;
    bus.i_udp_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_gnt(ok, who, w);
      e = exp_order.pop_front();
      n_checks++;
      if (!ok || who !== e) $display("FAIL grant_order[%0d]: got ok=%b udp=%b expected udp=%b", k, ok, who, e);
      else n_pass++;
      if (!ok) break;
      run_frame(who, 6, 6, 1'b0, held, lag);
    end
    bus.i_arp_req = 1'b0;
    bus.i_udp_req = 1'b0;
    measure_ifg(ifg, clean);
    n_checks++;
    if (o_arp_frames !== 16'd8 || o_udp_frames !== 16'd2 || exp_q.size() != 0)
      $display("FAIL starve_frames: got arp=%0d udp=%0d expected 8/2", o_arp_frames, o_udp_frames);
    else n_pass++;
  endtask

  task automatic test_start_timeout();
    bit ok, who, clean;
    int w, cnt, ifg;
    do_reset();
    bus.i_udp_req = 1'b1;
    wait_gnt(ok, who, w);
    cnt = 0;
    while (bus.o_udp_gnt === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    bus.i_udp_req = 1'b0;
    n_checks++;
    if (!ok || who !== 1'b1 || cnt != 64) $display("FAIL timeout_len: got grant held %0d cycles expected 64", cnt);
    else n_pass++;
    n_checks++;
    if (o_err_cnt !== 8'd1 || o_udp_frames !== 16'd0) $display("FAIL timeout_cnt: got err=%0d udp=%0d expected 1/0", o_err_cnt, o_udp_frames);
    else n_pass++;
    measure_ifg(ifg, clean);
    n_checks++;
    if (ifg != 12 || !clean) $display("FAIL timeout_ifg: got %0d cycles clean=%b expected 12 clean", ifg, clean);
    else n_pass++;
  endtask

  task automatic test_truncation();
    bit ok, who, held, lag, clean;
    int w, ifg;
    do_reset();
    bus.i_udp_req = 1'b1;
    wait_gnt(ok, who, w);
    bytes_seen = 0;
    run_frame(1'b1, 2000, 1530, 1'b1, held, lag);
    n_checks++;
    if (bytes_seen != 1530 || exp_q.size() != 0) $display("FAIL trunc_len: got %0d bytes expected 1530", bytes_seen);
    else n_pass++;
    n_checks++;
    if (!held) $display("FAIL trunc_gnt: got grant dropped before en fell expected held");
    else n_pass++;
    n_checks++;
    if (o_err_cnt !== 8'd1 || o_udp_frames !== 16'd0) $display("FAIL trunc_cnt: got err=%0d udp=%0d expected 1/0", o_err_cnt, o_udp_frames);
    else n_pass++;
    measure_ifg(ifg, clean);
    n_checks++;
    if (ifg != 12 || !clean) $display("FAIL trunc_ifg: got %0d cycles clean=%b expected 12 clean", ifg, clean);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit ok, who, held, lag, clean, en_before;
    int w, ifg;
    logic [7:0] d;
    do_reset();
    bus.i_arp_req = 1'b1;
    wait_gnt(ok, who, w);
    run_frame(1'b0, 10, 10, 1'b1, held, lag);
    measure_ifg(ifg, clean);
    bus.i_udp_req = 1'b1;
    wait_gnt(ok, who, w);
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      bus.i_udp_en = 1'b1; bus.i_udp_data = d;
      exp_q.push_back(d);
      tick();
    end
    #1;
    en_before = bus.eth_tx_data_en;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (en_before !== 1'b1 || bus.eth_tx_data_en !== 1'b0 || bus.o_udp_gnt !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL rst_async: got en before=%b after=%b gnt=%b busy=%b expected 1/0/0/0",
               en_before, bus.eth_tx_data_en, bus.o_udp_gnt, o_busy);
    else n_pass++;
    n_checks++;
    if (o_arp_frames !== 16'd0 || o_udp_frames !== 16'd0 || o_err_cnt !== 8'd0)
      $display("FAIL rst_counters: got arp=%0d udp=%0d err=%0d expected 0", o_arp_frames, o_udp_frames, o_err_cnt);
    else n_pass++;
    clear_inputs();
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    bus.i_udp_req = 1'b1;
    wait_gnt(ok, who, w);
    n_checks++;
    if (!ok || who !== 1'b1 || w != 2) $display("FAIL rst_rearb: got ok=%b udp=%b wait=%0d expected udp wait=2", ok, who, w);
    else n_pass++;
    run_frame(1'b1, 8, 8, 1'b1, held, lag);
    measure_ifg(ifg, clean);
    n_checks++;
    if (o_udp_frames !== 16'd1 || exp_q.size() != 0) $display("FAIL rst_frame: got udp=%0d expected 1", o_udp_frames);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_arp_frame();
    test_simultaneous();
    test_starvation();
    test_start_timeout();
    test_truncation();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
